// File: rtl/mem_wb_stage.sv
// MEM stage: runs loads/stores on a req/ack data bus and registers the writeback
// toward the register file. Stall is held while a bus access is outstanding.
module mem_wb_stage #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        men_valid,
  input  logic [1:0]  men_rf_wsel,
  input  logic        men_rf_we,
  input  logic        men_ram_we,
  input  logic [31:0] men_alu,
  input  logic [31:0] men_wd,
  input  logic [4:0]  men_wR,
  input  logic [31:0] men_rD2,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        stall,
  output logic        wb_rf_we,
  output logic [4:0]  wb_wR,
  output logic [31:0] wb_wD,
  output logic        bus_err
);
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t      r_state, w_state_nx;
  logic        r_req, r_we, r_wb_we, r_err;
  logic [31:0] r_addr, r_wdata, r_wD;
  logic [4:0]  r_wR;
  logic [CW-1:0] r_cnt;

  logic        w_req_nx, w_we_nx, w_wb_we_nx, w_err_nx;
  logic [31:0] w_addr_nx, w_wdata_nx, w_wD_nx;
  logic [4:0]  w_wR_nx;
  logic [CW-1:0] w_cnt_nx;
  logic        w_store, w_load, w_mis, w_tmo, w_stall;

  assign w_store = men_valid & men_ram_we;
  assign w_load  = men_valid & men_rf_we & (men_rf_wsel == 2'b01) & ~men_ram_we;
  assign w_mis   = (w_store | w_load) & (men_alu[1:0] != 2'b00);
  assign w_tmo   = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_req_nx   = r_req;
    w_we_nx    = r_we;
    w_addr_nx  = r_addr;
    w_wdata_nx = r_wdata;
    w_wb_we_nx = r_wb_we;
    w_wR_nx    = r_wR;
    w_wD_nx    = r_wD;
    w_err_nx   = 1'b0;
    w_cnt_nx   = r_cnt;
    w_stall    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mis) begin
          w_err_nx   = 1'b1;
          w_wb_we_nx = 1'b0;
        end else if (w_store | w_load) begin
          w_stall    = 1'b1;
          w_req_nx   = 1'b1;
          w_we_nx    = w_store;
          w_addr_nx  = {men_alu[31:2], 2'b00};
          w_wdata_nx = men_rD2;
          w_wb_we_nx = 1'b0;
          w_cnt_nx   = '0;
          w_state_nx = WAIT;
        end else begin
          w_wb_we_nx = men_valid & men_rf_we & (men_wR != 5'd0);
          w_wR_nx    = men_wR;
          w_wD_nx    = (men_rf_wsel == 2'b10) ? men_wd : men_alu;
        end
      end
      WAIT: begin
        // ack takes priority over a timeout in the same cycle
        if (dbus_ack) begin
          w_req_nx   = 1'b0;
          w_state_nx = IDLE;
          w_wR_nx    = men_wR;
          w_wb_we_nx = w_load & (men_wR != 5'd0);
          if (w_load) w_wD_nx = dbus_rdata;
        end else if (w_tmo) begin
          w_req_nx   = 1'b0;
          w_err_nx   = 1'b1;
          w_wb_we_nx = 1'b0;
          w_state_nx = IDLE;
        end else begin
          w_stall    = 1'b1;
          w_cnt_nx   = r_cnt + 1'b1;
          w_wb_we_nx = 1'b0;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wb_we <= 1'b0;
      r_wR    <= '0;
      r_wD    <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_req   <= w_req_nx;
      r_we    <= w_we_nx;
      r_addr  <= w_addr_nx;
      r_wdata <= w_wdata_nx;
      r_wb_we <= w_wb_we_nx;
      r_wR    <= w_wR_nx;
      r_wD    <= w_wD_nx;
      r_err   <= w_err_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // stall is masked during reset so upstream is never held by a discarded access
  assign stall      = rst_n & w_stall;
  assign dbus_req   = r_req;
  assign dbus_we    = r_we;
  assign dbus_addr  = r_addr;
  assign dbus_wdata = r_wdata;
  assign wb_rf_we   = r_wb_we;
  assign wb_wR      = r_wR;
  assign wb_wD      = r_wD;
  assign bus_err    = r_err;
endmodule
